// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Next-PC select encodings, NOP word and fetch FSM states.
package if_stage_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JMP = 2'b10,
    PCSRC_FOR = 2'b11
  } pcsrc_e;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/if_stage_pc_next.sv
// Next-PC candidate logic: PC+1 incrementer and 4:1 target select.
// Sequential fetch wraps modulo 2^WIDTH without any flag.
module pc_next_logic
  import if_stage_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] branch_ta,
  input  logic [WIDTH-1:0] jump_ta,
  input  logic [WIDTH-1:0] for_ta,
  output logic [WIDTH-1:0] pc_plus1,
  output logic [WIDTH-1:0] target
);

  assign pc_plus1 = pc + WIDTH'(1);

  always_comb begin
    target = pc_plus1;
    unique case (pcsrc_e'(pcsrc))
      PCSRC_SEQ: target = pc_plus1;
      PCSRC_BR:  target = branch_ta;
      PCSRC_JMP: target = jump_ta;
      PCSRC_FOR: target = for_ta;
      default:   target = pc_plus1;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID latch.
// Stall holds everything, kill injects a NOP while still redirecting.
module if_stage #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR =
    WIDTH'(if_stage_pkg::NOP_INSTR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] Branch_TA,
  input  logic [WIDTH-1:0] Jump_TA,
  input  logic [WIDTH-1:0] For_TA,
  input  logic             stall,
  input  logic             kill,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] instruction,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] NextPC,
  output logic [WIDTH-1:0] num_fetched
);

  if_stage_pkg::state_e state_q, state_d;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_id_q, pc_id_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] target;

  pc_next_logic #(
    .WIDTH(WIDTH)
  ) u_pc_next (
    .pc       (pc_q),
    .pcsrc    (PCSrc),
    .branch_ta(Branch_TA),
    .jump_ta  (Jump_TA),
    .for_ta   (For_TA),
    .pc_plus1 (pc_plus1),
    .target   (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= if_stage_pkg::BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc_id_q <= '0;
      npc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      npc_q   <= npc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall outranks kill; the three RUN cases are made disjoint here.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    npc_d   = npc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      if_stage_pkg::BOOT: begin
        state_d = if_stage_pkg::RUN;
      end
      if_stage_pkg::RUN: begin
        unique case (1'b1)
          stall: begin
          end
          (!stall && kill): begin
            instr_d = NOP_INSTR;
            pc_d    = target;
          end
          (!stall && !kill): begin
            instr_d = imem_data;
            pc_id_d = pc_q;
            npc_d   = pc_plus1;
            pc_d    = target;
            if (imem_data != NOP_INSTR)
              cnt_d = cnt_q + WIDTH'(1);
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_d = if_stage_pkg::BOOT;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign PC          = pc_id_q;
  assign NextPC      = npc_q;
  assign num_fetched = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction ROM.
// Expected values are hand-computed from the ROM contents below.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  PCSrc;
  logic [15:0] Branch_TA;
  logic [15:0] Jump_TA;
  logic [15:0] For_TA;
  logic        stall;
  logic        kill;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] instruction;
  logic [15:0] PC;
  logic [15:0] NextPC;
  logic [15:0] num_fetched;

  logic [15:0] rom [0:65535];

  int n_run;
  int n_fail;

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc      (PCSrc),
    .Branch_TA  (Branch_TA),
    .Jump_TA    (Jump_TA),
    .For_TA     (For_TA),
    .stall      (stall),
    .kill       (kill),
    .imem_data  (imem_data),
    .imem_addr  (imem_addr),
    .instruction(instruction),
    .PC         (PC),
    .NextPC     (NextPC),
    .num_fetched(num_fetched)
  );

  assign imem_data = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idid(input string tag,
                          input logic [15:0] ins,
                          input logic [15:0] pc,
                          input logic [15:0] npc,
                          input logic [15:0] addr,
                          input logic [15:0] cnt);
    chk({tag, ".instr"}, instruction, ins);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".npc"}, NextPC, npc);
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".cnt"}, num_fetched, cnt);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      rom[i] = {4'hE, a[11:0]};
    end
    rom[16'h0000] = 16'h1111;
    rom[16'h0001] = 16'h2222;
    rom[16'h0002] = 16'h3333;
    rom[16'h0003] = 16'h4444;
    rom[16'h0040] = 16'h4040;
    rom[16'h0080] = 16'h0000;

    reset     = 1'b1;
    PCSrc     = 2'b00;
    Branch_TA = '0;
    Jump_TA   = '0;
    For_TA    = '0;
    stall     = 1'b0;
    kill      = 1'b0;
    step();
    step();
    chk_idid("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    reset = 1'b0;

    step();
    chk_idid("boot", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk_idid("f0", 16'h1111, 16'h0000, 16'h0001, 16'h0001, 16'h0001);
    step();
    chk_idid("f1", 16'h2222, 16'h0001, 16'h0002, 16'h0002, 16'h0002);

    stall = 1'b1;
    step();
    chk_idid("stall1", 16'h2222, 16'h0001, 16'h0002, 16'h0002, 16'h0002);
    step();
    chk_idid("stall2", 16'h2222, 16'h0001, 16'h0002, 16'h0002, 16'h0002);
    stall = 1'b0;
    step();
    chk_idid("f2", 16'h3333, 16'h0002, 16'h0003, 16'h0003, 16'h0003);

    kill      = 1'b1;
    PCSrc     = 2'b01;
    Branch_TA = 16'h0040;
    step();
    chk_idid("kill", 16'h0000, 16'h0002, 16'h0003, 16'h0040, 16'h0003);
    kill  = 1'b0;
    PCSrc = 2'b00;
    step();
    chk_idid("br", 16'h4040, 16'h0040, 16'h0041, 16'h0041, 16'h0004);

    stall   = 1'b1;
    kill    = 1'b1;
    PCSrc   = 2'b10;
    Jump_TA = 16'h0100;
    step();
    chk_idid("stkill", 16'h4040, 16'h0040, 16'h0041, 16'h0041, 16'h0004);

    stall  = 1'b0;
    kill   = 1'b0;
    PCSrc  = 2'b11;
    For_TA = 16'hFFFF;
    step();
    chk_idid("for", 16'hE041, 16'h0041, 16'h0042, 16'hFFFF, 16'h0005);
    PCSrc = 2'b00;
    step();
    chk_idid("wrap", 16'hEFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0006);

    PCSrc   = 2'b10;
    Jump_TA = 16'h0080;
    step();
    chk_idid("jmp", 16'h1111, 16'h0000, 16'h0001, 16'h0080, 16'h0007);
    PCSrc = 2'b00;
    step();
    chk_idid("nop", 16'h0000, 16'h0080, 16'h0081, 16'h0081, 16'h0007);

    #2;
    reset = 1'b1;
    stall = 1'b1;
    kill  = 1'b1;
    #1;
    chk_idid("mrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step();
    stall = 1'b0;
    kill  = 1'b0;
    #2;
    reset = 1'b0;
    step();
    chk_idid("boot2", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk_idid("r0", 16'h1111, 16'h0000, 16'h0001, 16'h0001, 16'h0001);
    step();
    chk_idid("r1", 16'h2222, 16'h0001, 16'h0002, 16'h0002, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC from sequential, branch, jump or for-loop targets resolved in decode.
- Registers instruction, PC and NextPC into the IF/ID boundary, honouring stall (hold) and kill (flush to NOP).
- Keeps a retired-fetch counter for performance statistics.

Parameters:
- WIDTH, 16, datapath/PC width in bits.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, encoding injected into IF/ID on reset and kill.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- PCSrc  input  2  next-PC select: 00 = PC+1, 01 = Branch_TA, 10 = Jump_TA, 11 = For_TA.
- Branch_TA  input  WIDTH  branch target from decode.
- Jump_TA  input  WIDTH  jump/return target from decode.
- For_TA  input  WIDTH  for-loop target from decode.
- stall  input  1  hazard-unit hold request.
- kill  input  1  flush request; the instruction in IF is discarded.
- imem_data  input  WIDTH  instruction word at imem_addr (combinational read).
- imem_addr  output  WIDTH  equals current PC.
- instruction  output  WIDTH  IF/ID instruction register.
- PC  output  WIDTH  IF/ID copy of the fetched instruction's PC.
- NextPC  output  WIDTH  IF/ID copy of fetched PC+1 (feeds RR write in decode).
- num_fetched  output  WIDTH  count of non-NOP instructions accepted into IF/ID.

Behaviour:
- Reset (asynchronous, active-high):
  - pc_q = RESET_PC.
  - instruction = NOP_INSTR.
  - PC = 0, NextPC = 0, num_fetched = 0.
  - state = BOOT.
- Clock and arithmetic:
  - All other updates occur on the rising edge of clk.
  - PC+1 wraps modulo 2^WIDTH: 16'hFFFF goes to 16'h0000, with no flag.
- State BOOT: lasts one cycle after reset deassertion.
  - imem_addr = RESET_PC.
  - IF/ID keeps NOP.
  - pc_q unchanged.
  - Moves to RUN unconditionally; stall and kill are ignored in this state.
- State RUN: stays in RUN until reset. Per cycle, in priority order:
  1. stall=1: pc_q, instruction, PC, NextPC and num_fetched all hold. kill is ignored in this cycle (stall has priority; the hazard unit never asserts both in valid operation).
  2. kill=1: instruction = NOP_INSTR; PC and NextPC hold their old values; pc_q = selected target per PCSrc; num_fetched holds.
  3. Otherwise: instruction = imem_data, PC = pc_q, NextPC = pc_q+1, and pc_q = the PCSrc-selected value.
- num_fetched: increments by 1 when an instruction is accepted under case 3 and imem_data != NOP_INSTR. It wraps at 2^WIDTH.
- Redirect rule: a redirect (PCSrc != 00) without kill is legal. The wrong-path instruction is still captured, and flushing it is decode's responsibility.
- Latency:
  - The instruction at PC p appears on the instruction output 1 cycle after pc_q == p, absent stall.
  - Redirect to target t: pc_q == t on the next edge, and the t instruction is in IF/ID one edge later.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk, stall or kill.

Decomposition:
- Shared package:
  - PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JMP, PCSRC_FOR).
  - NOP_INSTR constant.
  - State enum {BOOT, RUN}.
- Sub-module pc_next_logic: combinational 4:1 target select plus PC+1 incrementer, reused by any future prefetch logic.

Test Plan:
- Reset with ROM[0..3] = 1111,2222,3333,4444; PCSrc=00 for 5 cycles:
  - cycle 1 (BOOT): NOP.
  - then instruction = 1111, 2222, 3333 with PC = 0, 1, 2 and NextPC = 1, 2, 3.
  - num_fetched = 3.
- stall=1 for 2 cycles while instruction = 2222: instruction, PC, imem_addr and num_fetched frozen; on release, 3333 follows.
- kill=1 with PCSrc=01 and Branch_TA=0x0040:
  - next edge: instruction = 0000 and pc_q = 0x0040.
  - following edge: instruction = ROM[0x40].
  - num_fetched unchanged by the flushed slot.
- stall=1, kill=1, PCSrc=10, Jump_TA=0x0100 together: everything holds; pc_q != 0x0100.
- pc_q = 0xFFFF, PCSrc=00: PC = 0xFFFF, NextPC = 0x0000, pc_q wraps to 0x0000.
- Assert reset mid-stream between clock edges: outputs go to reset values immediately; after deassertion, BOOT then fetch from 0x0000.
